// File: rtl/md_add_order_parser.sv
// Extracts Add Order messages from a length-prefixed byte stream (counters only with MD_PARSER_STATS_EN).
// Latency: valid_out/err_out register on the edge that accepts a message's final byte.
// Backpressure: none; every in_valid byte is accepted, idle cycles hold all state.
module md_add_order_parser #(
    parameter logic [7:0] ADD_TYPE = 8'h41,
    parameter int         ADD_LEN  = 11,
    parameter int         CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             valid_out,
    output logic [31:0]      price_out,
    output logic [31:0]      size_out,
    output logic             side_out,
    output logic             err_out,
    output logic [CNT_W-1:0] msg_count,
    output logic [CNT_W-1:0] err_count
);
    typedef enum logic [1:0] {S_LEN, S_TYPE, S_BODY, S_SKIP} state_t;

    localparam logic [7:0] ADD_LEN_B  = 8'(ADD_LEN);
    localparam logic [3:0] BODY_FIRST = 4'(ADD_LEN - 2);
    localparam logic [7:0] SIDE_BID   = 8'h42;
    localparam logic [7:0] SIDE_ASK   = 8'h53;

    state_t      state, state_n;
    logic [3:0]  remaining, rem_n;
    logic        bad, bad_n;
    logic        len_ok, len_ok_n;
    logic [71:0] stage, stage_n;
    logic        valid_n, err_n;
    logic        msg_end;

    assign msg_end = (remaining == 4'd1);

    always_comb begin
        state_n  = state;
        rem_n    = remaining;
        bad_n    = bad;
        len_ok_n = len_ok;
        stage_n  = stage;
        valid_n  = 1'b0;
        err_n    = 1'b0;
        if (in_valid) begin
            rem_n = remaining - 4'd1;
            case (state)
                S_LEN: begin
                    bad_n    = 1'b0;
                    len_ok_n = (in_data == ADD_LEN_B);
                    rem_n    = 4'(in_data - 8'd1);
                    if (in_data < 8'd2 || in_last) begin
                        err_n = 1'b1;
                    end else begin
                        state_n = S_TYPE;
                    end
                end
                S_TYPE: begin
                    // A wrong-length add is only reported once its last byte arrives.
                    if (msg_end) begin
                        state_n = S_LEN;
                        err_n   = (in_data == ADD_TYPE) && !len_ok;
                    end else if (in_last) begin
                        state_n = S_LEN;
                        err_n   = 1'b1;
                    end else if (in_data == ADD_TYPE) begin
                        state_n = len_ok ? S_BODY : S_SKIP;
                        bad_n   = !len_ok;
                    end else begin
                        state_n = S_SKIP;
                    end
                end
                S_BODY: begin
                    stage_n = {stage[63:0], in_data};
                    if (remaining == BODY_FIRST && in_data != SIDE_BID && in_data != SIDE_ASK)
                        bad_n = 1'b1;
                    if (msg_end) begin
                        state_n = S_LEN;
                        valid_n = !bad_n;
                        err_n   = bad_n;
                    end else if (in_last) begin
                        state_n = S_LEN;
                        err_n   = 1'b1;
                    end
                end
                S_SKIP: begin
                    if (msg_end) begin
                        state_n = S_LEN;
                        err_n   = bad;
                    end else if (in_last) begin
                        state_n = S_LEN;
                        err_n   = 1'b1;
                    end
                end
                default: state_n = S_LEN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_LEN;
            remaining <= '0;
            bad       <= 1'b0;
            len_ok    <= 1'b0;
            stage     <= '0;
            valid_out <= 1'b0;
            err_out   <= 1'b0;
            price_out <= '0;
            size_out  <= '0;
            side_out  <= 1'b0;
        end else begin
            state     <= state_n;
            remaining <= rem_n;
            bad       <= bad_n;
            len_ok    <= len_ok_n;
            stage     <= stage_n;
            valid_out <= valid_n;
            err_out   <= err_n;
            if (valid_n) begin
                price_out <= stage_n[63:32];
                size_out  <= stage_n[31:0];
                side_out  <= (stage_n[71:64] == SIDE_ASK);
            end
        end
    end

`ifdef MD_PARSER_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msg_count <= '0;
            err_count <= '0;
        end else begin
            if (valid_n && msg_count != {CNT_W{1'b1}})
                msg_count <= msg_count + CNT_W'(1);
            if (err_n && err_count != {CNT_W{1'b1}})
                err_count <= err_count + CNT_W'(1);
        end
    end
`else
    assign msg_count = '0;
    assign err_count = '0;
`endif

endmodule

// File: doc/md_add_order_parser.md
# md_add_order_parser

Upstream feed-handler stage in front of the top-of-book block. It consumes a raw byte stream of length-prefixed market-data messages and extracts "Add Order" messages. Each one is presented as a single-cycle `valid_out` pulse with 32-bit price, 32-bit size and a side bit, in exactly the form the order book's update inputs expect. Non-add messages are skipped, malformed messages are dropped and counted, and no backpressure is ever applied.

## Interface
- `ADD_TYPE`, default 8'h41: type byte identifying an Add Order message.
- `ADD_LEN`, default 11: required total length of an Add Order message, in bytes, including the length byte.
- `CNT_W`, default 16: width of the statistics counters.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  an input byte is present this cycle. It is always accepted.
- `in_data`  in  8  input byte.
- `in_last`  in  1  the byte is the final byte of its transport packet.
- `valid_out`  out  1  one-cycle pulse: a decoded add order is on the outputs.
- `price_out`  out  32  decoded price, big-endian on the wire.
- `size_out`  out  32  decoded size, big-endian on the wire.
- `side_out`  out  1  0 = BID, 1 = ASK.
- `err_out`  out  1  one-cycle pulse: a message was dropped as malformed.
- `msg_count`  out  CNT_W  number of add orders emitted, saturating.
- `err_count`  out  CNT_W  number of malformed messages, saturating.

## Operation
- Wire format: byte 0 = L, the total message length. Byte 1 = type. Add Order body, in order: side byte (0x42 'B' → 0, 0x53 'S' → 1), price[31:24..7:0], size[31:24..7:0].
- A packet may hold several back-to-back messages.
- FSM states: S_LEN, S_TYPE, S_BODY, S_SKIP. A 4-bit `remaining` counter tracks bytes left. State advances only on cycles where `in_valid` is high.
- **S_LEN:**
  - L < 2: error, stay in S_LEN. The next byte is treated as a new length.
  - Otherwise: `remaining = L-1` → S_TYPE.
- **S_TYPE:**
  - type == ADD_TYPE and L == ADD_LEN → S_BODY.
  - Any other type → S_SKIP.
  - type == ADD_TYPE with L != ADD_LEN: error, then S_SKIP.
  - L == 2: the message is complete after the type byte → S_LEN.
- **S_BODY:**
  - Shift bytes into side/price/size staging registers.
  - If the side byte is not 'B' or 'S', set a sticky `bad` flag and keep consuming the message.
  - On the last body byte: if `bad` is clear, pulse `valid_out`; if `bad` is set, pulse `err_out` instead. Then → S_LEN.
- **S_SKIP:** discard bytes until `remaining` reaches 0 → S_LEN.
- **Truncation:** `in_last` on a byte that is not the final byte of its message is an error (one per message). The FSM → S_LEN and the partial message is discarded.
  - `in_last` on the length byte with L ≥ 2 also counts as truncation.
- Each dropped message produces exactly one `err_out` pulse and one `err_count` increment.
- **Output registers:**
  - `price_out`, `size_out` and `side_out` are updated only when `valid_out` pulses, and hold their values otherwise.
  - Staging registers never drive the outputs directly.
- **Counters:** both saturate at 2^CNT_W−1 and never wrap.

## Timing
- Latency: `valid_out` and `err_out` are registered and assert on the clock edge that accepts the message's final byte. They are visible in the following cycle.
- Throughput: one byte per cycle with no bubbles. A new message may start on the byte immediately after the previous message's final byte.
- Deasserting `in_valid` mid-message holds all state. Gaps of any length are legal.
- Reset values: every output is 0, including `price_out`, `size_out`, `side_out`, both counters and both pulses. The FSM resets to S_LEN.
- Reset asserted mid-message: the partial message is lost with no `err_out` pulse. Parsing restarts with the next byte as a length byte.

## Configuration
- `MD_PARSER_STATS_EN`:
  - Defined: `msg_count` and `err_count` are implemented as specified.
  - Undefined: no counter flops are built, and both ports are tied to 0.
- `valid_out`, `err_out` and all parsing behaviour are identical in both builds.

## Test plan
- **Single ASK:** 0B 41 53 00 00 27 10 00 00 00 64 with `in_last` on the final byte → one `valid_out` pulse with price=10000, size=100, side=1; `msg_count`=1.
- **Skip then BID, no gaps:** 05 58 AA BB CC followed by 0B 41 42 00 00 00 05 00 00 00 07 → one `valid_out` pulse only, with price=5, size=7, side=0; `err_count`=0.
- **Bad side:** 0B 41 51 … (11 bytes total) → no `valid_out`; one `err_out` pulse; outputs keep their previous values.
- **Truncation:** 0B 41 42 00 00 with `in_last` on the 5th byte, followed by a valid BID → `err_count`=1, then a correct `valid_out` for the BID.
- **Length error resync:** 01 followed by a valid 11-byte ASK → one error for the 01, then a correct ASK output. Separately, 0A 41 … (10 bytes) → error, no `valid_out`.
- **Saturation and reset:** with CNT_W=2, send 5 add orders → `msg_count` stays at 3. Asserting `rst_n` low mid-message zeroes all outputs, and the next 11-byte add order decodes correctly.
